// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: entry layout,
// occupancy encoding and the zero-register write filter.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic              wr_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Occupancy encoded as {main_valid, skid_valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } wb_state_e;

    function automatic logic writes_reg(input wb_entry_t e);
        return e.wr_en && (e.addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// One write-back slot: a wb_entry_t payload with its valid flag.
// clear drops the valid flag and takes priority over load.
module wb_entry_reg
    import wb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      load_i,
    input  logic      clear_i,
    input  wb_entry_t entry_i,
    output logic      valid_o,
    output wb_entry_t entry_o
);

    logic      valid_d, valid_q;
    wb_entry_t entry_d, entry_q;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end
    end

    // NOTE: the payload is reset too so addr_o/data_o read 0 out of reset;
    // state is updated with <= only, so both slots update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/wb_write_stage.sv
// Registered write-back stage with a 2-entry skid buffer feeding the
// register-file write port; writes to the zero register are suppressed.
module wb_write_stage
    import wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic      main_valid, skid_valid;
    wb_entry_t main_entry, skid_entry;
    wb_entry_t in_entry, main_next;
    logic      main_load, main_clear, skid_load, skid_clear;
    logic      accept, drain;
    wb_state_e state;

    assign in_entry = '{wr_en: wr_en_i, addr: addr_i, data: data_i};
    assign state    = wb_state_e'({main_valid, skid_valid});

    // ready_o is the inverted skid flag, so it never sees ready_i or valid_i.
    assign ready_o = !skid_valid;
    assign accept  = valid_i && ready_o;
    assign drain   = main_valid && ready_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_next  = in_entry;
        if (flush_i) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept) begin
                        main_load = drain;
                        skid_load = !drain;
                    end else begin
                        main_clear = drain;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_load  = 1'b1;
                        main_next  = skid_entry;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    wb_entry_reg u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (main_load),
        .clear_i (main_clear),
        .entry_i (main_next),
        .valid_o (main_valid),
        .entry_o (main_entry)
    );

    wb_entry_reg u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .entry_i (in_entry),
        .valid_o (skid_valid),
        .entry_o (skid_entry)
    );

    assign valid_o = main_valid;
    assign wr_en_o = main_valid && writes_reg(main_entry);
    assign addr_o  = main_entry.addr;
    assign data_o  = main_entry.data;

endmodule

// File: doc/wb_write_stage.md
Name: wb_write_stage

Overview:
- Registered write-back stage between the MEM pipeline stage and the register-file write port.
- Captures the destination register, write enable and data.
- Drives the write-enable (`wr_en_o`) that enables the register file's address decoder tree, plus the address and data that go with it.
- Includes a 2-entry skid buffer so the register file can back-pressure without combinational ready paths. Also suppresses writes to the zero register.

Parameters:
- ADDR_W, 5, register address width (32 architectural registers).
- DATA_W, 64, register data width.
- ZERO_REG, 31, address whose writes are discarded (XZR).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream entry valid.
- ready_o  output  1  stage can accept an entry this cycle.
- wr_en_i  input  1  upstream RegWrite.
- addr_i  input  ADDR_W  destination register.
- data_i  input  DATA_W  write-back data.
- flush_i  input  1  discard all held entries (branch/exception squash).
- valid_o  output  1  head entry valid toward register file.
- ready_i  input  1  register file accepts head entry.
- wr_en_o  output  1  decoder enable, equal to valid_o AND head.wr_en AND (head.addr != ZERO_REG).
- addr_o  output  ADDR_W  head destination register.
- data_o  output  DATA_W  head data.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - main and skid valid flags cleared; entry fields cleared to 0.
  - Outputs: valid_o=0, wr_en_o=0, addr_o=0, data_o=0, ready_o=1.
  - Reset asserted mid-transfer loses all held entries; no write is issued in the reset cycle.
- Handshakes:
  - Input transfer when valid_i && ready_o at a rising edge.
  - Output transfer when valid_o && ready_i.
- Latency: 1 cycle. An entry accepted at edge N appears on the outputs after edge N.
- ready_o: comes directly from a register. ready_o = !skid_valid. Never depends combinationally on ready_i or valid_i.
- States (encoded by {main_valid, skid_valid}):
  - EMPTY (0,0): accept → ONE.
  - ONE (1,0):
    - accept && drain → ONE; main is replaced by the new entry.
    - accept && !drain → FULL; the new entry goes to skid.
    - drain only → EMPTY.
  - FULL (1,1): ready_o=0.
    - drain → ONE; skid moves to main.
    - no drain → hold.
  - (0,1) is unreachable. The implementation must never enter it.
- Ordering: strictly FIFO. Skid is always younger than main.
- Flush:
  - flush_i=1 at an edge clears both valid flags → EMPTY. Any concurrent input transfer is dropped; flush wins.
  - A head entry presented in the flush cycle with ready_i=1 counts as written. The register file samples wr_en_o in that same cycle.
- Zero register:
  - Entries with addr=ZERO_REG or wr_en=0 still occupy the stage and handshake normally.
  - For those entries wr_en_o=0, so no decoder output asserts.
- Data/address fields are held stable while valid_o && !ready_i.
- wr_en_o is glitch-free relative to the clock: it is derived only from registered state.

Decomposition:
- Package wb_pkg holds:
  - localparams ADDR_W, DATA_W, ZERO_REG.
  - typedef struct packed wb_entry_t {wr_en, addr[ADDR_W-1:0], data[DATA_W-1:0]}.
- One sub-module: wb_entry_reg.
  - A wb_entry_t register with valid flag, load and clear inputs, and asynchronous active-low reset.
  - Instantiated twice, for main and skid.
- The top module contains the next-state logic and the output gating.

Test Plan:
1. Reset mid-stream:
   - Stimulus: hold entries in FULL, pull rst_ni low between edges.
   - Required: valid_o=0, wr_en_o=0, ready_o=1 immediately, without waiting for a clock edge.
2. Single write:
   - Stimulus: valid_i=1, wr_en_i=1, addr_i=5, data_i=0xDEAD_BEEF, ready_i=1.
   - Required: next cycle valid_o=1, wr_en_o=1, addr_o=5, data_o=0xDEAD_BEEF; one cycle later valid_o=0.
3. Back-pressure:
   - Stimulus: ready_i=0; send addr 1, 2, 3 on consecutive cycles.
   - Required: ready_o drops after the second accept; addr 3 is held upstream.
   - Then raise ready_i: outputs present 1, 2, 3 in order, with no loss or duplication.
4. Zero register:
   - Stimulus: addr_i=31, wr_en_i=1, data_i=0x1234.
   - Required: valid_o=1 but wr_en_o=0.
   - Also: wr_en_i=0 with addr_i=7 gives wr_en_o=0.
5. Flush:
   - Stimulus: in FULL (addr 1, 2), assert flush_i together with valid_i (addr 9).
   - Required: next cycle valid_o=0 and ready_o=1; addr 9 never appears on the outputs.
6. Streaming:
   - Stimulus: valid_i=1 and ready_i=1 continuously with addr 0..30 incrementing.
   - Required: one write per cycle, addr_o trails addr_i by exactly 1 cycle, ready_o stays 1 throughout.
